// File: rtl/regfile_wr_arbiter_if.sv
// Writeback bus between the two requesters (ALU, load unit) and the register-file
// write arbiter; the arbiter side uses the slave modport.
interface regfile_wr_arbiter_if #(
    parameter int DATA_WIDTH = 4,
    parameter int REG_WIDTH  = 5
);
    logic                  req0_valid;
    logic [REG_WIDTH-1:0]  req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [REG_WIDTH-1:0]  req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;
    logic                  wen;
    logic [REG_WIDTH-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  stall;
    logic [7:0]            conflict_cnt;

    modport master (
        output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready, wen, wr_addr, wr_data, stall, conflict_cnt
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready, wen, wr_addr, wr_data, stall, conflict_cnt
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Two-slot register-file writeback arbiter with registered write port.
// Optional macro ROUND_ROBIN_EN selects round-robin arbitration; default is slot-1 priority.
module regfile_wr_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int REG_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wr_arbiter_if.slave  bus
);
    logic                  full0_q, full0_d, full1_q, full1_d;
    logic [REG_WIDTH-1:0]  addr0_q, addr0_d, addr1_q, addr1_d;
    logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic                  wen_q, wen_d;
    logic [REG_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  grant0_s, grant1_s, stall_s;
`ifdef ROUND_ROBIN_EN
    logic                  last_grant_q, last_grant_d;
`endif

    assign stall_s          = full0_q & full1_q;
    assign bus.req0_ready   = ~full0_q | grant0_s;
    assign bus.req1_ready   = ~full1_q | grant1_s;
    assign bus.stall        = stall_s;
    assign bus.wen          = wen_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.conflict_cnt = cnt_q;

    // Grant selection: one full slot wins per cycle.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (full0_q && full1_q) begin
`ifdef ROUND_ROBIN_EN
            if (last_grant_q) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
`else
            grant1_s = 1'b1;
`endif
        end else if (full0_q) begin
            grant0_s = 1'b1;
        end else if (full1_q) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Next state for slots, write port and conflict counter.
    always_comb begin
        full0_d   = full0_q;
        addr0_d   = addr0_q;
        data0_d   = data0_q;
        full1_d   = full1_q;
        addr1_d   = addr1_q;
        data1_d   = data1_q;
        wen_d     = grant0_s | grant1_s;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cnt_d     = cnt_q;

        if (grant1_s) begin
            wr_addr_d = addr1_q;
            wr_data_d = data1_q;
        end else if (grant0_s) begin
            wr_addr_d = addr0_q;
            wr_data_d = data0_q;
        end else begin
            wr_addr_d = wr_addr_q;
            wr_data_d = wr_data_q;
        end

        // A refill at the grant edge takes precedence over clearing the slot.
        if (bus.req0_valid && bus.req0_ready) begin
            full0_d = 1'b1;
            addr0_d = bus.req0_addr;
            data0_d = bus.req0_data;
        end else if (grant0_s) begin
            full0_d = 1'b0;
        end else begin
            full0_d = full0_q;
        end

        if (bus.req1_valid && bus.req1_ready) begin
            full1_d = 1'b1;
            addr1_d = bus.req1_addr;
            data1_d = bus.req1_data;
        end else if (grant1_s) begin
            full1_d = 1'b0;
        end else begin
            full1_d = full1_q;
        end

        if (stall_s && (cnt_q != 8'd255)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full0_q   <= 1'b0;
            addr0_q   <= {REG_WIDTH{1'b0}};
            data0_q   <= {DATA_WIDTH{1'b0}};
            full1_q   <= 1'b0;
            addr1_q   <= {REG_WIDTH{1'b0}};
            data1_q   <= {DATA_WIDTH{1'b0}};
            wen_q     <= 1'b0;
            wr_addr_q <= {REG_WIDTH{1'b0}};
            wr_data_q <= {DATA_WIDTH{1'b0}};
            cnt_q     <= 8'd0;
        end else begin
            full0_q   <= full0_d;
            addr0_q   <= addr0_d;
            data0_q   <= data0_d;
            full1_q   <= full1_d;
            addr1_q   <= addr1_d;
            data1_q   <= data1_d;
            wen_q     <= wen_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef ROUND_ROBIN_EN
    // Most recent grant; reset value 1 hands the first contended grant to slot 0.
    always_comb begin
        if (grant0_s) begin
            last_grant_d = 1'b0;
        end else if (grant1_s) begin
            last_grant_d = 1'b1;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Last-grant register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus random traffic
// against a pending-request / register-file reference model.
module tb_regfile_wr_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    regfile_wr_arbiter_if #(.DATA_WIDTH(4), .REG_WIDTH(5)) bus ();

    regfile_wr_arbiter #(.DATA_WIDTH(4), .REG_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: pending request per requester, expected write port, register files.
    bit         pend [2];
    logic [4:0] paddr[2];
    logic [3:0] pdata[2];
    int         m_last;
    logic       e_wen;
    logic [4:0] e_addr;
    logic [3:0] e_data;
    int         e_cnt;
    logic [3:0] model_mem[32];
    logic [3:0] dut_mem[32];
    int         wlog_addr[$];
    int         wlog_data[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int winner();
        if (!pend[0] && !pend[1]) return -1;
        if (pend[0] && !pend[1]) return 0;
        if (pend[1] && !pend[0]) return 1;
`ifdef ROUND_ROBIN_EN
        return (m_last == 0) ? 1 : 0;
`else
        return 1;
`endif
    endfunction

    task automatic model_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        m_last = 1;
        e_wen = 1'b0; e_addr = 5'd0; e_data = 4'd0; e_cnt = 0;
    endtask

    task automatic step(input bit v0, input logic [4:0] a0, input logic [3:0] d0,
                        input bit v1, input logic [4:0] a1, input logic [3:0] d1);
        int  w;
        bit  r0, r1, both;
        @(negedge clk);
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
        #1;
        w    = winner();
        r0   = !pend[0] || (w == 0);
        r1   = !pend[1] || (w == 1);
        both = pend[0] && pend[1];
        chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, r0});
        chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, r1});
        chk("stall", {31'd0, bus.stall}, {31'd0, both});
        chk("wen", {31'd0, bus.wen}, {31'd0, e_wen});
        chk("wr_addr", {27'd0, bus.wr_addr}, {27'd0, e_addr});
        chk("wr_data", {28'd0, bus.wr_data}, {28'd0, e_data});
        chk("conflict_cnt", {24'd0, bus.conflict_cnt}, e_cnt);
        if (bus.wen) begin
            dut_mem[bus.wr_addr] = bus.wr_data;
            wlog_addr.push_back(int'(bus.wr_addr));
            wlog_data.push_back(int'(bus.wr_data));
        end
        @(posedge clk);
        e_wen = (w >= 0);
        if (w >= 0) begin
            e_addr = paddr[w];
            e_data = pdata[w];
            model_mem[paddr[w]] = pdata[w];
            m_last = w;
            pend[w] = 1'b0;
        end
        if (both && e_cnt < 255) e_cnt++;
        if (v0 && r0) begin pend[0] = 1'b1; paddr[0] = a0; pdata[0] = d0; end
        if (v1 && r1) begin pend[1] = 1'b1; paddr[1] = a1; pdata[1] = d1; end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0);
    endtask

    // Asynchronous reset pulse in mid-cycle with requesters still driving valid.
    task automatic do_reset();
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_addr = 5'd9;  bus.req0_data = 4'hC;
        bus.req1_valid = 1'b1; bus.req1_addr = 5'd10; bus.req1_data = 4'hD;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_wen", {31'd0, bus.wen}, 32'd0);
        chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd1);
        chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd1);
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_wr_addr", {27'd0, bus.wr_addr}, 32'd0);
        chk("rst_wr_data", {28'd0, bus.wr_data}, 32'd0);
        chk("rst_cnt", {24'd0, bus.conflict_cnt}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        rst_n = 1'b1;
        wlog_addr.delete();
        wlog_data.delete();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin model_mem[i] = 4'd0; dut_mem[i] = 4'd0; end
        bus.req0_valid = 1'b0; bus.req0_addr = 5'd0; bus.req0_data = 4'd0;
        bus.req1_valid = 1'b0; bus.req1_addr = 5'd0; bus.req1_data = 4'd0;
        model_reset();
        #12;
        do_reset();
        idle(2);

        // Single request: write appears two cycles after the request.
        step(1'b1, 5'd3, 4'hA, 1'b0, 5'd0, 4'd0);
        idle(3);
        chk("single_mem", {28'd0, dut_mem[3]}, 32'hA);
        chk("single_nwrites", wlog_addr.size(), 32'd1);

        // Simultaneous requests.
        do_reset();
        step(1'b1, 5'd1, 4'h5, 1'b1, 5'd2, 4'h6);
        idle(4);
        chk("simul_cnt", {24'd0, bus.conflict_cnt}, 32'd1);
        chk("simul_nwrites", wlog_addr.size(), 32'd2);
`ifdef ROUND_ROBIN_EN
        chk("simul_first", wlog_addr[0], 32'd1);
        chk("simul_second", wlog_addr[1], 32'd2);
`else
        chk("simul_first", wlog_addr[0], 32'd2);
        chk("simul_second", wlog_addr[1], 32'd1);
`endif

        // Same-address ordering.
        do_reset();
        step(1'b1, 5'd7, 4'h2, 1'b1, 5'd7, 4'h1);
        idle(4);
`ifdef ROUND_ROBIN_EN
        chk("same_addr_mem", {28'd0, dut_mem[7]}, 32'h1);
`else
        chk("same_addr_mem", {28'd0, dut_mem[7]}, 32'h2);
`endif
        chk("same_addr_nwrites", wlog_addr.size(), 32'd2);

`ifdef ROUND_ROBIN_EN
        // Both held valid: grants alternate starting with slot 0 (data tags the source).
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 5'd20, 4'h0, 1'b1, 5'd21, 4'h1);
        idle(3);
        for (int i = 0; i < 4; i++) chk("rr_alternate", wlog_data[i], i % 2);
`endif

        // Saturation of the conflict counter.
        do_reset();
        for (int i = 0; i < 300; i++)
            step(1'b1, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
                 1'b1, 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
        chk("sat_cnt", {24'd0, bus.conflict_cnt}, 32'd255);
        idle(3);

        // Reset while both slots are full: pending writes discarded.
        step(1'b1, 5'd12, 4'h3, 1'b1, 5'd13, 4'h4);
        do_reset();
        idle(4);
        chk("rst_discard_nwrites", wlog_addr.size(), 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
        idle(4);
        for (int i = 0; i < 32; i++) chk("final_mem", {28'd0, dut_mem[i]}, {28'd0, model_mem[i]});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
